// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with branch/jump/call/return redirects,
// stall hold and a small circular return-address stack.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = 4,
    parameter int              IMM_SHIFT    = 2,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_imm,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_step,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    localparam int          PW   = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW:0]     r_count;
    logic            r_err;

    logic [XLEN-1:0] w_pc_plus_step;
    logic [XLEN-1:0] w_branch_tgt;
    logic [XLEN-1:0] w_pc_next;
    logic [PW-1:0]   w_top_idx;
    logic            w_push;
    logic            w_pop;
    logic            w_underflow;

    assign w_pc_plus_step = r_pc + XLEN'(STEP);
    assign w_branch_tgt   = w_pc_plus_step + (branch_imm << IMM_SHIFT);
    // Write pointer points at the next free slot; top of stack sits one below.
    assign w_top_idx      = r_wptr - PW'(1);

    always_comb begin
        w_pc_next   = w_pc_plus_step;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        if (stall) begin
            w_pc_next = r_pc;
        end else if (ret) begin
            if (r_count != '0) begin
                w_pc_next = r_ras[w_top_idx];
                w_pop     = 1'b1;
            end else begin
                w_underflow = 1'b1;
            end
        end else if (jump) begin
            w_pc_next = jump_target;
            w_push    = call;
        end else if (branch_taken) begin
            w_pc_next = w_branch_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_VECTOR;
            r_wptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pc  <= w_pc_next;
            r_err <= w_underflow;
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
                if (r_count != FULL) begin
                    r_count <= r_count + (PW + 1)'(1);
                end
            end else if (w_pop) begin
                r_wptr  <= w_top_idx;
                r_count <= r_count - (PW + 1)'(1);
            end
        end
    end

    // Entry contents need no reset; a full push overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_ras[r_wptr] <= w_pc_plus_step;
        end
    end

    assign pc           = r_pc;
    assign pc_plus_step = w_pc_plus_step;
    assign ras_empty    = (r_count == '0);
    assign ras_full     = (r_count == FULL);
    assign ras_err      = r_err;

endmodule
